// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;

    // Width of the slice handled by the ripple adder each cycle
    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_fa4.sv
// 4-bit ripple adder slice: {co,s} = a + b + ci.
module nibble_serial_adder_fa4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    // Single combinational add with the carry folded into the top bit
    always_comb begin
        {co, s} = (NIB_W+1)'(a) + (NIB_W+1)'(b) + (NIB_W+1)'(ci);
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that pushes one nibble per clock through a
// shared 4-bit adder, LSB nibble first, chaining the carry in a register.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_co,
    output logic             busy
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned CNT_W = $clog2(NIB);
    localparam int unsigned IDX_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    // Reject widths that do not split into at least two whole nibbles
    if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] nib_base;
    logic [NIB_W-1:0] fa_a, fa_b, fa_s;
    logic             fa_co;

    // Bit offset of the nibble currently being processed
    always_comb begin
        nib_base = {cnt_q, 2'b00};
        fa_a     = a_q[nib_base +: NIB_W];
        fa_b     = b_q[nib_base +: NIB_W];
    end

    nibble_serial_adder_fa4 u_fa4 (
        .a  (fa_a),
        .b  (fa_b),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Next-state and datapath update for IDLE -> RUN -> DONE sequencing
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        co_d    = co_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_ci;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_d[nib_base +: NIB_W] = fa_s;
                carry_d                = fa_co;
                cnt_d                  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    co_d    = fa_co;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake flags decode straight from the state register
    always_comb begin
        in_ready  = rst_n && (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        out_s     = s_q;
        out_co    = co_q;
    end

endmodule
